// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_unit
// Purpose  : Multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB) with halt on
//            ECALL when x17 == 10, plus a retired-instruction counter.
// Revision : 1.0  initial release
// ============================================================================
module mc_control_unit #(
    parameter int CNT_W = 32,
    parameter int OPC_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             is_ten,
    input  logic             bcond,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             pc_source,
    output logic             is_halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [OPC_W-1:0] c_OP_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] c_OP_IARITH = 7'b0010011;
    localparam logic [OPC_W-1:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] c_OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] c_OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] c_OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] c_OP_ECALL  = 7'b1110011;

    typedef enum logic [2:0] {
        c_ST_IF      = 3'd0,
        c_ST_ID      = 3'd1,
        c_ST_EX      = 3'd2,
        c_ST_MEM     = 3'd3,
        c_ST_WB      = 3'd4,
        c_ST_JALR_WB = 3'd5,
        c_ST_PC4     = 3'd6,
        c_ST_HALT    = 3'd7
    } state_t;

    state_t           r_state_q;
    state_t           w_state_d;
    logic [CNT_W-1:0] r_count_q;
    logic [CNT_W-1:0] w_count_d;
    logic             w_known_op;

    // Opcodes that have a real execute step; anything else retires as a NOP.
    assign w_known_op = (opcode == c_OP_R)      || (opcode == c_OP_IARITH) ||
                        (opcode == c_OP_LOAD)   || (opcode == c_OP_STORE)  ||
                        (opcode == c_OP_BRANCH) || (opcode == c_OP_JAL)    ||
                        (opcode == c_OP_JALR);

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 2'd0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'b00;
        pc_source  = 1'b0;
        is_halted  = 1'b0;
        w_state_d  = r_state_q;

        if (reset) begin
            w_state_d = c_ST_IF;
        end else begin
            case (r_state_q)
                c_ST_IF: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        w_state_d = c_ST_ID;
                    end
                end
                c_ST_ID: begin
                    alu_src_b = 2'd2;
                    if (opcode == c_OP_ECALL)
                        w_state_d = is_ten ? c_ST_HALT : c_ST_PC4;
                    else if (w_known_op)
                        w_state_d = c_ST_EX;
                    else
                        w_state_d = c_ST_PC4;
                end
                c_ST_EX: begin
                    case (opcode)
                        c_OP_R, c_OP_IARITH: begin
                            alu_src_a = 1'b1;
                            alu_src_b = (opcode == c_OP_R) ? 2'd0 : 2'd2;
                            alu_op    = 2'b10;
                            w_state_d = c_ST_WB;
                        end
                        c_OP_LOAD, c_OP_STORE: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'd2;
                            w_state_d = c_ST_MEM;
                        end
                        c_OP_BRANCH: begin
                            alu_src_a = 1'b1;
                            alu_op    = 2'b01;
                            if (bcond) begin
                                pc_write  = 1'b1;
                                pc_source = 1'b1;
                                w_state_d = c_ST_IF;
                            end else begin
                                w_state_d = c_ST_PC4;
                            end
                        end
                        c_OP_JAL: begin
                            alu_src_b  = 2'd1;
                            mem_to_reg = 2'd2;
                            reg_write  = 1'b1;
                            pc_write   = 1'b1;
                            pc_source  = 1'b1;
                            w_state_d  = c_ST_IF;
                        end
                        c_OP_JALR: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'd2;
                            w_state_d = c_ST_JALR_WB;
                        end
                        default: w_state_d = c_ST_PC4;
                    endcase
                end
                c_ST_MEM: begin
                    i_or_d = 1'b1;
                    if (opcode == c_OP_LOAD) begin
                        mem_read = 1'b1;
                        if (mem_ready)
                            w_state_d = c_ST_WB;
                    end else begin
                        mem_write = 1'b1;
                        if (mem_ready) begin
                            pc_write  = 1'b1;
                            alu_src_b = 2'd1;
                            w_state_d = c_ST_IF;
                        end
                    end
                end
                c_ST_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (opcode == c_OP_LOAD) ? 2'd1 : 2'd0;
                    pc_write   = 1'b1;
                    alu_src_b  = 2'd1;
                    w_state_d  = c_ST_IF;
                end
                c_ST_JALR_WB: begin
                    alu_src_b  = 2'd1;
                    mem_to_reg = 2'd2;
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                    pc_source  = 1'b1;
                    w_state_d  = c_ST_IF;
                end
                c_ST_PC4: begin
                    pc_write  = 1'b1;
                    alu_src_b = 2'd1;
                    w_state_d = c_ST_IF;
                end
                c_ST_HALT: begin
                    is_halted = 1'b1;
                end
                default: w_state_d = c_ST_IF;
            endcase
        end
    end

    // Every PC update marks one retired instruction.
    assign w_count_d   = r_count_q + CNT_W'(pc_write);
    assign instr_count = reset ? '0 : r_count_q;

    always_ff @(posedge clk) begin
        r_state_q <= w_state_d;
        if (reset)
            r_count_q <= '0;
        else
            r_count_q <= w_count_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_unit
// Purpose  : Randomized scoreboard bench for mc_control_unit against a
//            per-instruction control-sequence reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mc_control_unit;

    localparam int CW = 4;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IARITH = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_ECALL  = 7'b1110011;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    opcode = 7'd0;
    logic          is_ten = 1'b0;
    logic          bcond = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_write, ir_write, i_or_d, mem_read, mem_write;
    logic [1:0]    mem_to_reg;
    logic          reg_write, alu_src_a;
    logic [1:0]    alu_src_b, alu_op;
    logic          pc_source, is_halted;
    logic [CW-1:0] instr_count;

    mc_control_unit #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .is_ten     (is_ten),
        .bcond      (bcond),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .is_halted  (is_halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0]   w;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            failures = 0;
    logic [CW-1:0] mcount = '0;

    function automatic logic [14:0] mk(input bit pcw, input bit irw, input bit iod,
                                       input bit mr, input bit mw, input logic [1:0] m2r,
                                       input bit rw, input bit sa, input logic [1:0] sb,
                                       input logic [1:0] op, input bit ps, input bit h);
        return {pcw, irw, iod, mr, mw, m2r, rw, sa, sb, op, ps, h};
    endfunction

    function automatic bit known(input logic [6:0] op);
        return op == c_OP_R || op == c_OP_IARITH || op == c_OP_LOAD || op == c_OP_STORE ||
               op == c_OP_BRANCH || op == c_OP_JAL || op == c_OP_JALR;
    endfunction

    wire [14:0] act = {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                       reg_write, alu_src_a, alu_src_b, alu_op, pc_source, is_halted};

    // Monitor: one expected entry per cycle, plus cycle-level exclusivity rules.
    always @(negedge clk) begin
        checks++;
        if (reg_write && mem_write) begin
            failures++;
            $display("FAIL rw_mw_excl t=%0t reg_write=%b mem_write=%b required not both", $time, reg_write, mem_write);
        end
        checks++;
        if (mem_read && mem_write) begin
            failures++;
            $display("FAIL rd_wr_excl t=%0t mem_read=%b mem_write=%b required not both", $time, mem_read, mem_write);
        end
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (act !== mon_e.w) begin
                failures++;
                $display("FAIL ctrl t=%0t op=%b got=%b exp=%b", $time, opcode, act, mon_e.w);
            end
            checks++;
            if (instr_count !== mon_e.cnt) begin
                failures++;
                $display("FAIL count t=%0t got=%0d exp=%0d", $time, instr_count, mon_e.cnt);
            end
        end
    end

    task automatic push_exp(input logic [14:0] w, input logic [CW-1:0] c);
        exp_t e;
        e.w = w;
        e.cnt = c;
        sb_q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            push_exp(15'd0, '0);
            reset = 1'b1;
            mem_ready = 1'($urandom);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        mcount = '0;
    endtask

    // Builds the expected control sequence for one instruction, then drives it.
    task automatic run_instr(input logic [6:0] op, input int w1, input int w2,
                             input bit b, input bit t, input int abort);
        logic [14:0] wq[$];
        bit          mq[$];
        bit          halted = 1'b0;
        logic [14:0] w_pc4  = mk(1,0,0,0,0,2'd0,0,0,2'd1,2'b00,0,0);
        logic [14:0] w_link = mk(1,0,0,0,0,2'd2,1,0,2'd1,2'b00,1,0);
        logic [14:0] w_ag   = mk(0,0,0,0,0,2'd0,0,1,2'd2,2'b00,0,0);
        opcode = op;
        bcond  = b;
        is_ten = t;
        repeat (w1) begin wq.push_back(mk(0,0,0,1,0,2'd0,0,0,2'd0,2'b00,0,0)); mq.push_back(1'b0); end
        wq.push_back(mk(0,1,0,1,0,2'd0,0,0,2'd0,2'b00,0,0)); mq.push_back(1'b1);
        wq.push_back(mk(0,0,0,0,0,2'd0,0,0,2'd2,2'b00,0,0)); mq.push_back(1'($urandom));
        if (op == c_OP_ECALL && t) begin
            halted = 1'b1;
            repeat (20) begin wq.push_back(mk(0,0,0,0,0,2'd0,0,0,2'd0,2'b00,0,1)); mq.push_back(1'($urandom)); end
        end else if (op == c_OP_ECALL || !known(op)) begin
            wq.push_back(w_pc4); mq.push_back(1'($urandom));
        end else if (op == c_OP_R || op == c_OP_IARITH) begin
            wq.push_back(mk(0,0,0,0,0,2'd0,0,1,(op == c_OP_R) ? 2'd0 : 2'd2,2'b10,0,0)); mq.push_back(1'($urandom));
            wq.push_back(mk(1,0,0,0,0,2'd0,1,0,2'd1,2'b00,0,0)); mq.push_back(1'($urandom));
        end else if (op == c_OP_LOAD) begin
            wq.push_back(w_ag); mq.push_back(1'($urandom));
            repeat (w2) begin wq.push_back(mk(0,0,1,1,0,2'd0,0,0,2'd0,2'b00,0,0)); mq.push_back(1'b0); end
            wq.push_back(mk(0,0,1,1,0,2'd0,0,0,2'd0,2'b00,0,0)); mq.push_back(1'b1);
            wq.push_back(mk(1,0,0,0,0,2'd1,1,0,2'd1,2'b00,0,0)); mq.push_back(1'($urandom));
        end else if (op == c_OP_STORE) begin
            wq.push_back(w_ag); mq.push_back(1'($urandom));
            repeat (w2) begin wq.push_back(mk(0,0,1,0,1,2'd0,0,0,2'd0,2'b00,0,0)); mq.push_back(1'b0); end
            wq.push_back(mk(1,0,1,0,1,2'd0,0,0,2'd1,2'b00,0,0)); mq.push_back(1'b1);
        end else if (op == c_OP_BRANCH) begin
            wq.push_back(mk(b,0,0,0,0,2'd0,0,1,2'd0,2'b01,b,0)); mq.push_back(1'($urandom));
            if (!b) begin wq.push_back(w_pc4); mq.push_back(1'($urandom)); end
        end else if (op == c_OP_JAL) begin
            wq.push_back(w_link); mq.push_back(1'($urandom));
        end else begin
            wq.push_back(w_ag); mq.push_back(1'($urandom));
            wq.push_back(w_link); mq.push_back(1'($urandom));
        end

        for (int i = 0; i < wq.size(); i++) begin
            if (i == abort) begin
                do_reset(1);
                return;
            end
            push_exp(wq[i], mcount);
            if (wq[i][14]) mcount = mcount + 1'b1;
            mem_ready = mq[i];
            @(posedge clk);
            #1;
        end
        if (halted) do_reset(2);
    endtask

    initial begin
        logic [6:0] ops[9];
        logic [6:0] op;
        ops = '{c_OP_R, c_OP_IARITH, c_OP_LOAD, c_OP_STORE, c_OP_BRANCH,
                c_OP_JAL, c_OP_JALR, c_OP_ECALL, 7'd0};
        @(posedge clk);
        #1;
        do_reset(3);
        run_instr(c_OP_R,      0, 0, 0, 0, -1);
        run_instr(c_OP_LOAD,   0, 3, 0, 0, -1);
        run_instr(c_OP_BRANCH, 0, 0, 1, 0, -1);
        run_instr(c_OP_BRANCH, 1, 0, 0, 0, -1);
        run_instr(c_OP_ECALL,  0, 0, 0, 0, -1);
        run_instr(c_OP_JAL,    0, 0, 0, 0, -1);
        run_instr(c_OP_JALR,   0, 0, 0, 0, -1);
        run_instr(c_OP_IARITH, 2, 0, 0, 0, -1);
        run_instr(7'b1111111,  0, 0, 0, 0, -1);
        run_instr(c_OP_STORE,  0, 2, 0, 0, 4);
        run_instr(c_OP_STORE,  0, 1, 0, 0, -1);
        run_instr(c_OP_ECALL,  0, 0, 0, 1, -1);
        for (int n = 0; n < 300; n++) begin
            op = ops[$urandom_range(0, 8)];
            if (op == 7'd0) op = 7'($urandom);
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom),
                      ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1);
        end
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Multi-cycle RV32I control FSM that sequences fetch, decode, execute, memory and writeback for one instruction at a time. It sits directly upstream of the register file. Its reg_write drives the register file's write_enable, and it consumes the register file's is_ten flag (x17 == 10) to decide whether an ECALL halts the core. It also drives the PC, IR, memory and ALU operand-select controls of the multi-cycle datapath, and keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter
OPC_W, 7, opcode field width (fixed by ISA, not for override)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
opcode  input  7  IR[6:0], valid from ID onward
is_ten  input  1  register file flag, x17 == 10
bcond  input  1  ALU branch-condition result, valid in EX of BRANCH
mem_ready  input  1  memory completes access this cycle
pc_write  output  1  unconditional PC load
ir_write  output  1  load IR from memory data
i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
mem_to_reg  output  2  rd source: 0=ALUOut, 1=MDR, 2=ALU result (link PC+4)
reg_write  output  1  register file write_enable
alu_src_a  output  1  0=PC, 1=A register
alu_src_b  output  2  0=B register, 1=const 4, 2=immediate
alu_op  output  2  00=add, 01=branch compare, 10=funct-decoded
pc_source  output  1  0=ALU result, 1=ALUOut
is_halted  output  1  core halted
instr_count  output  CNT_W  retired-instruction count

Behaviour:
- Outputs are combinational from state, plus the mem_ready and bcond qualifiers listed below. Every control output is 0 in any cycle not listed.
- While reset is high: all outputs 0, instr_count 0, state IF at the next edge.
- Reset mid-instruction aborts it. No write enables are asserted while reset is high.
- States: IF, ID, EX, MEM, WB, JALR_WB, PC4, HALT.
- Opcodes: R 0110011, IARITH 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, ECALL 1110011.
- IF:
  - Drive mem_read=1, i_or_d=0.
  - While mem_ready=0, stay in IF.
  - When mem_ready=1, assert ir_write=1 and go to ID.
- ID:
  - Drive alu_src_a=0, alu_src_b=2, alu_op=00, so ALUOut <= PC+imm.
  - ECALL with is_ten=1 goes to HALT.
  - ECALL with is_ten=0 goes to PC4.
  - Unknown opcode goes to PC4 (executes as a NOP).
  - All other opcodes go to EX.
- EX, R / IARITH:
  - Drive alu_src_a=1, alu_src_b=0 (R) or 2 (IARITH), alu_op=10.
  - Go to WB.
- EX, LOAD / STORE:
  - Drive alu_src_a=1, alu_src_b=2, alu_op=00.
  - Go to MEM.
- EX, BRANCH:
  - Drive alu_src_a=1, alu_src_b=0, alu_op=01.
  - bcond=1: pc_write=1, pc_source=1, then IF (instruction retires).
  - bcond=0: go to PC4.
- EX, JAL:
  - Drive alu_src_a=0, alu_src_b=1, mem_to_reg=2, reg_write=1, pc_write=1, pc_source=1.
  - Go to IF (retires).
- EX, JALR:
  - Drive alu_src_a=1, alu_src_b=2, alu_op=00.
  - Go to JALR_WB.
- JALR_WB:
  - Drive alu_src_a=0, alu_src_b=1, mem_to_reg=2, reg_write=1, pc_write=1, pc_source=1.
  - Go to IF (retires).
- MEM:
  - Drive i_or_d=1; mem_read=1 for LOAD, mem_write=1 for STORE.
  - While mem_ready=0, hold MEM with outputs held.
  - mem_ready=1 on LOAD: go to WB.
  - mem_ready=1 on STORE: also drive pc_write=1, alu_src_a=0, alu_src_b=1, pc_source=0, then IF (retires).
- WB:
  - Drive reg_write=1, mem_to_reg=1 (LOAD) or 0 (otherwise).
  - Drive pc_write=1, alu_src_a=0, alu_src_b=1, pc_source=0.
  - Go to IF (retires).
- PC4:
  - Drive pc_write=1, alu_src_a=0, alu_src_b=1, pc_source=0.
  - Go to IF (retires).
- HALT:
  - is_halted=1, all other control outputs 0.
  - Stays in HALT until reset; mem_ready is ignored.
- instr_count:
  - Increments by 1 on each clock edge where pc_write=1 and reset=0.
  - Wraps modulo 2^CNT_W.
  - HALT does not count.
- reg_write is never asserted in the same cycle as mem_write.
- At most one of mem_read and mem_write is high in any cycle.

Test Plan:
1. Reset, then opcode=0110011 with mem_ready=1 in IF -> states IF, ID, EX, WB. reg_write=1 only in WB with mem_to_reg=0. instr_count 0->1 after 4 cycles.
2. LOAD with mem_ready low for 3 cycles in MEM -> MEM held 4 cycles with mem_read=1, i_or_d=1. WB has mem_to_reg=1. Total 8 cycles, instr_count=1.
3. BRANCH with bcond=1 -> EX asserts pc_write=1, pc_source=1, 3 cycles. With bcond=0 -> PC4 follows, 4 cycles. No reg_write in either case.
4. ECALL with is_ten=0 -> PC4, then IF, count+1. ECALL with is_ten=1 -> HALT, is_halted=1 held for 20 cycles, instr_count frozen, mem_read=0.
5. JAL -> EX asserts reg_write=1, mem_to_reg=2, pc_write=1, pc_source=1 in the same cycle. JALR -> the same controls appear in JALR_WB, one cycle later.
6. Assert reset during MEM of a STORE -> mem_write=0 that cycle. Next state IF, instr_count=0, is_halted=0.
